// File: rtl/timer_pkg.sv
// Shared types and defaults for the multi-mode countdown timer.
package timer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_e;

    localparam int W_DEFAULT         = 8;
    localparam bit EDGE_TICK_DEFAULT = 1'b1;
endpackage

// File: rtl/multi_mode_timer_if.sv
// Control/status bundle between a timer client (master) and the timer (slave).
interface multi_mode_timer_if #(
    parameter int W = timer_pkg::W_DEFAULT
);
    logic [W-1:0] value;
    logic         tick_enable;
    logic         start_timer;
    logic         pause;
    logic         abort;
    logic         auto_reload;
    logic [W-1:0] remaining;
    logic         busy;
    logic         expired;
    logic         expired_pulse;

    modport master (
        output value, tick_enable, start_timer, pause, abort, auto_reload,
        input  remaining, busy, expired, expired_pulse
    );
    modport slave (
        input  value, tick_enable, start_timer, pause, abort, auto_reload,
        output remaining, busy, expired, expired_pulse
    );
endinterface

// File: rtl/multi_mode_timer_tick_strobe.sv
// Turns the slow time base into a single-cycle tick, either per rising edge
// or per high cycle, with no added latency.
module tick_strobe #(
    parameter bit EDGE_TICK = timer_pkg::EDGE_TICK_DEFAULT
) (
    input  logic clk,
    input  logic Reset_Sync,
    input  logic tick_enable_i,
    output logic tick_o
);
    logic prev_tick_q;

    // Tracks tick_enable in every state so a held-high input never re-fires.
    always_ff @(posedge clk) begin
        if (Reset_Sync) prev_tick_q <= 1'b0;
        else            prev_tick_q <= tick_enable_i;
    end

    generate
        if (EDGE_TICK) begin : g_edge
            assign tick_o = tick_enable_i & ~prev_tick_q;
        end else begin : g_level
            assign tick_o = tick_enable_i;
        end
    endgenerate
endmodule

// File: rtl/multi_mode_timer.sv
// Countdown timer with pause, abort, one-shot/periodic modes and expiry
// reported both as a held level and a one-cycle pulse.
module multi_mode_timer
    import timer_pkg::*;
#(
    parameter int W         = W_DEFAULT,
    parameter bit EDGE_TICK = EDGE_TICK_DEFAULT
) (
    input  logic                  clk,
    input  logic                  Reset_Sync,
    multi_mode_timer_if.slave     bus
);
    localparam logic [W-1:0] CNT_ONE = W'(1);

    state_e       state_q;
    logic [W-1:0] count_q;
    logic [W-1:0] reload_q;
    logic         busy_q;
    logic         expired_q;
    logic         pulse_q;
    logic         tick;

    tick_strobe #(.EDGE_TICK(EDGE_TICK)) u_tick (
        .clk           (clk),
        .Reset_Sync    (Reset_Sync),
        .tick_enable_i (bus.tick_enable),
        .tick_o        (tick)
    );

    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (bus.abort) begin
                state_q   <= IDLE;
                count_q   <= '0;
                busy_q    <= 1'b0;
                expired_q <= 1'b0;
            end else if (bus.start_timer) begin
                count_q  <= bus.value;
                reload_q <= bus.value;
                // A zero duration expires immediately, even in periodic mode.
                if (bus.value == '0) begin
                    state_q   <= DONE;
                    busy_q    <= 1'b0;
                    expired_q <= 1'b1;
                    pulse_q   <= 1'b1;
                end else begin
                    state_q   <= RUN;
                    busy_q    <= 1'b1;
                    expired_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    RUN: begin
                        if (bus.pause) begin
                            state_q <= PAUSED;
                        end else if (tick) begin
                            if (count_q > CNT_ONE) begin
                                count_q <= count_q - CNT_ONE;
                            end else if (bus.auto_reload) begin
                                count_q <= reload_q;
                                pulse_q <= 1'b1;
                            end else begin
                                count_q   <= '0;
                                state_q   <= DONE;
                                busy_q    <= 1'b0;
                                expired_q <= 1'b1;
                                pulse_q   <= 1'b1;
                            end
                        end
                    end
                    // Resuming takes effect next cycle, so a tick coinciding
                    // with the release of pause is dropped.
                    PAUSED: if (!bus.pause) state_q <= RUN;
                    default: ;
                endcase
            end
        end
    end

    assign bus.remaining     = count_q;
    assign bus.busy          = busy_q;
    assign bus.expired       = expired_q;
    assign bus.expired_pulse = pulse_q;
endmodule

// File: tb/tb_multi_mode_timer.sv
// Directed bench: stimulus queues expected expiry events, a monitor checks
// each expired_pulse against the queue head.
module tb_multi_mode_timer;
    typedef struct {
        int         cyc;
        logic       expired;
        logic       busy;
        logic [7:0] rem;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc_cnt = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    multi_mode_timer_if #(.W(8)) bus ();

    multi_mode_timer #(.W(8), .EDGE_TICK(1'b1)) dut (
        .clk        (clk),
        .Reset_Sync (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (!rst && bus.expired_pulse) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d rem=%0d", cyc_cnt, bus.remaining);
            end else begin
                mon_e = sb.pop_front();
                if (cyc_cnt != mon_e.cyc || bus.expired !== mon_e.expired ||
                    bus.busy !== mon_e.busy || bus.remaining !== mon_e.rem) begin
                    failures++;
                    $display("FAIL expiry_event got cyc=%0d exp=%b busy=%b rem=%0d want cyc=%0d exp=%b busy=%b rem=%0d",
                             cyc_cnt, bus.expired, bus.busy, bus.remaining,
                             mon_e.cyc, mon_e.expired, mon_e.busy, mon_e.rem);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", n, act, exp);
        end
    endtask

    task automatic push_exp(input logic e_exp, input logic e_busy, input logic [7:0] e_rem);
        exp_t e;
        e.cyc = cyc_cnt + 1;
        e.expired = e_exp;
        e.busy = e_busy;
        e.rem = e_rem;
        sb.push_back(e);
    endtask

    // One tick_enable period: high 20 ns, low 20 ns; optionally an expiry is due.
    task automatic tick_p(input bit due, input logic e_exp, input logic e_busy, input logic [7:0] e_rem);
        bus.tick_enable = 1'b1;
        if (due) push_exp(e_exp, e_busy, e_rem);
        cyc(); cyc();
        bus.tick_enable = 1'b0;
        cyc(); cyc();
    endtask

    task automatic start(input logic [7:0] v);
        bus.value = v;
        bus.start_timer = 1'b1;
        cyc();
        bus.start_timer = 1'b0;
    endtask

    initial begin
        bus.value = '0;
        bus.tick_enable = 1'b0;
        bus.start_timer = 1'b0;
        bus.pause = 1'b0;
        bus.abort = 1'b0;
        bus.auto_reload = 1'b0;
        repeat (3) cyc();
        chk("rst_remaining", bus.remaining, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_expired", bus.expired, 0);
        chk("rst_pulse", bus.expired_pulse, 0);
        rst = 1'b0;
        cyc();

        // One-shot, value 6
        start(8'd6);
        chk("t1_busy", bus.busy, 1);
        chk("t1_rem0", bus.remaining, 6);
        for (int i = 1; i <= 5; i++) begin
            tick_p(1'b0, 1'b0, 1'b0, 8'd0);
            chk($sformatf("t1_rem%0d", i), bus.remaining, 6 - i);
        end
        tick_p(1'b1, 1'b1, 1'b0, 8'd0);
        chk("t1_expired_held", bus.expired, 1);
        chk("t1_pulse_low", bus.expired_pulse, 0);
        chk("t1_busy_done", bus.busy, 0);

        // Periodic, value 3; live value changes must not affect reload
        bus.auto_reload = 1'b1;
        start(8'd3);
        bus.value = 8'd9;
        for (int i = 1; i <= 7; i++) begin
            tick_p(i % 3 == 0, 1'b0, 1'b1, 8'd3);
            chk($sformatf("t2_rem%0d", i), bus.remaining, (i % 3 == 0) ? 3 : 3 - (i % 3));
        end
        chk("t2_expired_low", bus.expired, 0);
        chk("t2_busy", bus.busy, 1);
        bus.auto_reload = 1'b0;

        // Pause after 2 ticks for 4 tick periods
        start(8'd5);
        tick_p(1'b0, 1'b0, 1'b0, 8'd0);
        tick_p(1'b0, 1'b0, 1'b0, 8'd0);
        bus.pause = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            tick_p(1'b0, 1'b0, 1'b0, 8'd0);
            chk($sformatf("t3_hold%0d", i), bus.remaining, 3);
        end
        chk("t3_busy_paused", bus.busy, 1);
        bus.pause = 1'b0;
        cyc();
        tick_p(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t3_rem2", bus.remaining, 2);
        tick_p(1'b0, 1'b0, 1'b0, 8'd0);
        tick_p(1'b1, 1'b1, 1'b0, 8'd0);
        chk("t3_expired", bus.expired, 1);

        // Restart mid-run: 8 -> 4 after 2 ticks
        start(8'd8);
        tick_p(1'b0, 1'b0, 1'b0, 8'd0);
        tick_p(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t4_rem6", bus.remaining, 6);
        start(8'd4);
        chk("t4_reload4", bus.remaining, 4);
        chk("t4_expired_clr", bus.expired, 0);
        for (int i = 0; i < 3; i++) tick_p(1'b0, 1'b0, 1'b0, 8'd0);
        tick_p(1'b1, 1'b1, 1'b0, 8'd0);
        tick_p(1'b0, 1'b0, 1'b0, 8'd0);
        tick_p(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t4_done_rem", bus.remaining, 0);

        // Abort mid-run, then a zero-length start
        start(8'd5);
        tick_p(1'b0, 1'b0, 1'b0, 8'd0);
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        chk("t5_abort_busy", bus.busy, 0);
        chk("t5_abort_rem", bus.remaining, 0);
        chk("t5_abort_exp", bus.expired, 0);
        tick_p(1'b0, 1'b0, 1'b0, 8'd0);
        bus.value = 8'd0;
        bus.start_timer = 1'b1;
        push_exp(1'b1, 1'b0, 8'd0);
        cyc();
        bus.start_timer = 1'b0;
        chk("t5_zero_pulse", bus.expired_pulse, 1);
        chk("t5_zero_expired", bus.expired, 1);
        cyc();

        // Reset out of DONE; following tick is ignored while idle
        rst = 1'b1;
        cyc();
        chk("t6_rst_exp", bus.expired, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_pulse", bus.expired_pulse, 0);
        rst = 1'b0;
        tick_p(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t6_idle_rem", bus.remaining, 0);
        chk("t6_idle_busy", bus.busy, 0);

        repeat (4) cyc();
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
